hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised hazard and forwarding controller for the in-order RISC-V pipeline. It tracks every in-flight register write from issue (decode→execute) until writeback. For each operand of the instruction in decode it produces either a forwarding-stage select or a decode stall, and it sequences pipeline flushes after a taken branch or jump. It replaces per-opcode forwarding equations with a depth-, latency- and flush-length-parametrised scoreboard, and adds load-use interlock.

## Interface
- REG_ADDR_W, 5, register address width.
- FWD_DEPTH, 3, tracked stages after issue: 1 = EX, 2 = MEM, 3 = WB.
- LOAD_STAGE, 2, first stage index at which load data is forwardable. Range 1..FWD_DEPTH.
- FLUSH_CYCLES, 2, flush pulse length after a redirect. Minimum 1.
- FSEL_W, $clog2(FWD_DEPTH+1), derived, forward-select width.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_rs1, issue_rs2  in  REG_ADDR_W  source registers.
- issue_use_rs1, issue_use_rs2  in  1  operand is actually read.
- issue_rd  in  REG_ADDR_W  destination register.
- issue_wr  in  1  instruction writes rd.
- issue_is_load  in  1  instruction is a load.
- redirect  in  1  taken branch/jal/jalr resolved in EX this cycle.
- stall  out  1  hold fetch and decode; insert bubble into EX.
- flush  out  1  kill the instructions in IF and ID.
- fwd_sel_rs1, fwd_sel_rs2  out  FSEL_W  operand source. 0 = regfile; k = result of the stage-k instruction.
- inflight  out  FSEL_W  count of valid entries that write a register.

## Operation
- The scoreboard is a shift register of FWD_DEPTH entries. Each entry holds {valid, rd, avail}. Entry k holds the instruction issued k cycles ago.
- Each clock, entry k moves to entry k+1. Entry FWD_DEPTH retires, since its write lands in the regfile that cycle.
- Entry 1 load rule: the decode instruction is loaded when issue_valid & issue_wr & (issue_rd != 0) & !stall & !flush. Otherwise entry 1 receives a bubble (valid = 0).
- avail = LOAD_STAGE if issue_is_load, else 1.
- Hazard lookup, done separately per operand with r = rs1 or rs2:
  - If use = 0 or r = 0: sel = 0, no hazard.
  - Otherwise find the smallest k with valid & rd == r. The youngest match wins.
  - No match: sel = 0.
  - Match with k >= avail: sel = k.
  - Match with k < avail: operand hazard.
- stall = issue_valid & !flush & !redirect & (hazard rs1 | hazard rs2).
- While stall is high, fwd_sel outputs still reflect the lookup. Decode re-evaluates each cycle as the producer advances.
- Flush FSM has two states, IDLE and FLUSH, with a down-counter.
  - IDLE: redirect → FLUSH, counter = FLUSH_CYCLES-1.
  - FLUSH: counter decrements each cycle. It returns to IDLE after the cycle in which counter == 0.
  - Redirect while in FLUSH reloads the counter to FLUSH_CYCLES-1.
  - flush = 1 in state FLUSH.
- During flush: stall = 0, fwd_sel = 0, no issue recorded.
- Entries already in the scoreboard are never killed. They are older than the redirecting instruction or are the redirect itself.
- inflight = number of valid entries.

## Timing
- stall, fwd_sel_rs1 and fwd_sel_rs2 are combinational from the current issue inputs, redirect and the registered scoreboard. They are valid in the same cycle.
- flush is registered. It rises the cycle after redirect and stays high exactly FLUSH_CYCLES cycles, counted from the last redirect.
- Load-use penalty: LOAD_STAGE-1 stall cycles for an immediately dependent instruction. At the default, 1 cycle, after which sel = 2.
- ALU-to-ALU dependency: zero stall, sel = 1.
- redirect together with a hazard: redirect wins, stall = 0, and the decode instruction is discarded.
- Async reset takes effect immediately, mid-operation included:
  - all entries invalid;
  - FSM in IDLE, counter = 0;
  - stall = 0, flush = 0, fwd_sel = 0, inflight = 0.
- The first rising edge after rst_n deasserts is a normal cycle.

## Test plan
- ALU chain. Issue add x5, then next cycle add x6,x5,x5 → fwd_sel_rs1 = fwd_sel_rs2 = 1, stall = 0. A third instruction reading x5 and x6 → sel_rs1 = 2, sel_rs2 = 1.
- Load-use. Issue lw x5, then add x6,x5,x0 → stall = 1 for 1 cycle with entry 1 a bubble. Next cycle stall = 0 and fwd_sel_rs1 = 2. Repeat with LOAD_STAGE = 3 → 2 stall cycles, then sel = 3.
- Priority and x0:
  - addi x7; addi x7; read x7 → sel = 1.
  - Write to x0, then read x0 → sel = 0, stall = 0, inflight unchanged.
  - Reading x7 with use = 0 → sel = 0.
- Retirement. Write x9, then 3 unrelated instructions, then read x9 → sel = 0. At the depth-3 position → sel = 3.
- Flush. Redirect pulse → flush = 1 for exactly 2 cycles starting the next cycle, stall = 0, and no entries recorded. A second redirect during the first flush cycle → flush lasts 2 cycles from the second redirect.
- Async reset mid-stall. Assert rst_n = 0 while stall = 1 and inflight = 2 → all outputs 0 immediately, without a clock edge. After release, a dependent read → sel = 0.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake between the issue stage and the hazard scoreboard.
// The scoreboard sits on the slave modport; decode/control logic drives the master side.
interface hazard_scoreboard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int FWD_DEPTH  = 3,
  parameter int FSEL_W     = $clog2(FWD_DEPTH + 1)
);
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  issue_use_rs1;
  logic                  issue_use_rs2;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_wr;
  logic                  issue_is_load;
  logic                  redirect;
  logic                  stall;
  logic                  flush;
  logic [FSEL_W-1:0]     fwd_sel_rs1;
  logic [FSEL_W-1:0]     fwd_sel_rs2;
  logic [FSEL_W-1:0]     inflight;

  modport master (
    output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    output issue_rd, issue_wr, issue_is_load, redirect,
    input  stall, flush, fwd_sel_rs1, fwd_sel_rs2, inflight
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
    input  issue_rd, issue_wr, issue_is_load, redirect,
    output stall, flush, fwd_sel_rs1, fwd_sel_rs2, inflight
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight register writes: per-operand forwarding
// select or load-use stall for the decode instruction, plus post-redirect flush sequencing.
module hazard_scoreboard #(
  parameter int REG_ADDR_W   = 5,
  parameter int FWD_DEPTH    = 3,
  parameter int LOAD_STAGE   = 2,
  parameter int FLUSH_CYCLES = 2,
  parameter int FSEL_W       = $clog2(FWD_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  hazard_scoreboard_if.slave bus
);
  localparam int                 CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   CNT_LOAD   = CNT_W'(FLUSH_CYCLES - 1);
  localparam logic [FSEL_W-1:0]  LOAD_AVAIL = FSEL_W'(LOAD_STAGE);
  localparam logic [FSEL_W-1:0]  ALU_AVAIL  = FSEL_W'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FLUSH = 1'b1} state_e;

  // Index k = stage k after issue (1 = EX ... FWD_DEPTH = WB)
  logic                  valid_q [1:FWD_DEPTH];
  logic                  valid_d [1:FWD_DEPTH];
  logic [REG_ADDR_W-1:0] rd_q    [1:FWD_DEPTH];
  logic [REG_ADDR_W-1:0] rd_d    [1:FWD_DEPTH];
  logic [FSEL_W-1:0]     avail_q [1:FWD_DEPTH];
  logic [FSEL_W-1:0]     avail_d [1:FWD_DEPTH];
  logic [FSEL_W-1:0]     inflight_q, inflight_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  hit1_s, hit2_s, use1_s, use2_s, haz1_s, haz2_s;
  logic [FSEL_W-1:0]     k1_s, k2_s, av1_s, av2_s, sel1_s, sel2_s;
  logic                  flush_s, stall_s, load_s;

  assign flush_s = (state_q == S_FLUSH);

  // Youngest-match lookup per operand; scanning oldest to youngest lets the youngest overwrite
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    k1_s   = '0;
    k2_s   = '0;
    av1_s  = '0;
    av2_s  = '0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (valid_q[k] && (rd_q[k] == bus.issue_rs1)) begin
        hit1_s = 1'b1;
        k1_s   = FSEL_W'(k);
        av1_s  = avail_q[k];
      end else begin
        hit1_s = hit1_s;
      end
      if (valid_q[k] && (rd_q[k] == bus.issue_rs2)) begin
        hit2_s = 1'b1;
        k2_s   = FSEL_W'(k);
        av2_s  = avail_q[k];
      end else begin
        hit2_s = hit2_s;
      end
    end
    use1_s  = bus.issue_use_rs1 && (bus.issue_rs1 != '0);
    use2_s  = bus.issue_use_rs2 && (bus.issue_rs2 != '0);
    haz1_s  = use1_s && hit1_s && (k1_s < av1_s);
    haz2_s  = use2_s && hit2_s && (k2_s < av2_s);
    sel1_s  = (use1_s && hit1_s && !flush_s) ? k1_s : '0;
    sel2_s  = (use2_s && hit2_s && !flush_s) ? k2_s : '0;
    stall_s = bus.issue_valid && !flush_s && !bus.redirect && (haz1_s || haz2_s);
  end

  // Shift entries toward WB and record the decode instruction when it really issues
  always_comb begin
    load_s     = bus.issue_valid && bus.issue_wr && (bus.issue_rd != '0) &&
                 !stall_s && !flush_s && !bus.redirect;
    valid_d[1] = load_s;
    rd_d[1]    = load_s ? bus.issue_rd : '0;
    avail_d[1] = load_s ? (bus.issue_is_load ? LOAD_AVAIL : ALU_AVAIL) : '0;
    for (int k = 2; k <= FWD_DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      avail_d[k] = avail_q[k-1];
    end
    inflight_d = '0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      inflight_d = inflight_d + FSEL_W'(valid_d[k]);
    end
  end

  // Flush sequencer: any redirect (re)loads the counter so flush spans FLUSH_CYCLES from the last one
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.redirect) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_LOAD;
        end else begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_FLUSH: begin
        if (bus.redirect) begin
          state_d = S_FLUSH;
          cnt_d   = CNT_LOAD;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_FLUSH;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        rd_q[k]    <= '0;
        avail_q[k] <= '0;
      end
      inflight_q <= '0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      avail_q    <= avail_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.stall       = stall_s;
  assign bus.flush       = flush_s;
  assign bus.fwd_sel_rs1 = sel1_s;
  assign bus.fwd_sel_rs2 = sel2_s;
  assign bus.inflight    = inflight_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: default-parameter scoreboard for most scenarios, plus a
// LOAD_STAGE=3 instance for the longer load-use interlock.
module tb_hazard_scoreboard;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  hazard_scoreboard_if #(.REG_ADDR_W(5), .FWD_DEPTH(3)) bi ();
  hazard_scoreboard_if #(.REG_ADDR_W(5), .FWD_DEPTH(3)) bi3 ();

  hazard_scoreboard #(.REG_ADDR_W(5), .FWD_DEPTH(3), .LOAD_STAGE(2), .FLUSH_CYCLES(2))
    dut (.clk(clk), .rst_n(rst_n), .bus(bi));
  hazard_scoreboard #(.REG_ADDR_W(5), .FWD_DEPTH(3), .LOAD_STAGE(3), .FLUSH_CYCLES(2))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bi3));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                     input logic [4:0] r2, input logic u2, input logic [4:0] rd,
                     input logic wr, input logic ld, input logic rdir);
    bi.issue_valid   = v;
    bi.issue_rs1     = r1;
    bi.issue_use_rs1 = u1;
    bi.issue_rs2     = r2;
    bi.issue_use_rs2 = u2;
    bi.issue_rd      = rd;
    bi.issue_wr      = wr;
    bi.issue_is_load = ld;
    bi.redirect      = rdir;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    for (int i = 0; i < 3; i++) tick();
  endtask

  initial begin
    clk = 1'b0;
    rst_n = 1'b0;
    n_chk = 0;
    n_fail = 0;
    idle();
    bi3.issue_valid = 1'b0; bi3.issue_rs1 = 5'd0; bi3.issue_use_rs1 = 1'b0;
    bi3.issue_rs2 = 5'd0; bi3.issue_use_rs2 = 1'b0; bi3.issue_rd = 5'd0;
    bi3.issue_wr = 1'b0; bi3.issue_is_load = 1'b0; bi3.redirect = 1'b0;
    #12;
    check_val("rst_stall", int'(bi.stall), 0);
    check_val("rst_flush", int'(bi.flush), 0);
    check_val("rst_sel1", int'(bi.fwd_sel_rs1), 0);
    check_val("rst_inflight", int'(bi.inflight), 0);
    tick();
    rst_n = 1'b1;

    // ALU chain
    drv(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk); check_val("alu0_stall", int'(bi.stall), 0);
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_val("alu1_sel1", int'(bi.fwd_sel_rs1), 1);
    check_val("alu1_sel2", int'(bi.fwd_sel_rs2), 1);
    check_val("alu1_stall", int'(bi.stall), 0);
    check_val("alu1_inflight", int'(bi.inflight), 1);
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_val("alu2_sel1", int'(bi.fwd_sel_rs1), 2);
    check_val("alu2_sel2", int'(bi.fwd_sel_rs2), 1);
    check_val("alu2_inflight", int'(bi.inflight), 2);
    tick();
    drain();
    check_val("drain_inflight", int'(bi.inflight), 0);

    // Load-use, LOAD_STAGE = 2
    drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
    @(negedge clk); check_val("lu_stall", int'(bi.stall), 1);
    tick();
    @(negedge clk);
    check_val("lu_stall_clr", int'(bi.stall), 0);
    check_val("lu_sel1", int'(bi.fwd_sel_rs1), 2);
    check_val("lu_sel2_x0", int'(bi.fwd_sel_rs2), 0);
    check_val("lu_bubble_inflight", int'(bi.inflight), 1);
    tick();
    drain();

    // Priority and x0
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    drv(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("prio_sel1", int'(bi.fwd_sel_rs1), 1);
    check_val("nouse_sel2", int'(bi.fwd_sel_rs2), 0);
    tick();
    drain();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("x0_sel1", int'(bi.fwd_sel_rs1), 0);
    check_val("x0_stall", int'(bi.stall), 0);
    check_val("x0_inflight", int'(bi.inflight), 0);
    tick();
    drain();

    // Retirement
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0);
    @(negedge clk); check_val("ret_depth3_sel", int'(bi.fwd_sel_rs1), 3);
    tick();
    drv(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_val("ret_retired_sel", int'(bi.fwd_sel_rs1), 0);
    check_val("ret_inflight", int'(bi.inflight), 3);
    tick();
    drain();

    // Redirect with a pending load-use hazard, then flush window
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check_val("rdir_stall", int'(bi.stall), 0);
    check_val("rdir_flush_pre", int'(bi.flush), 0);
    tick();
    drv(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_val("fl1_flush", int'(bi.flush), 1);
    check_val("fl1_sel", int'(bi.fwd_sel_rs1), 0);
    check_val("fl1_inflight", int'(bi.inflight), 1);
    tick();
    @(negedge clk);
    check_val("fl2_flush", int'(bi.flush), 1);
    check_val("fl2_stall", int'(bi.stall), 0);
    check_val("fl2_inflight", int'(bi.inflight), 1);
    tick();
    idle();
    @(negedge clk);
    check_val("fl3_flush", int'(bi.flush), 0);
    check_val("fl3_inflight", int'(bi.inflight), 0);
    tick();

    // Second redirect during the first flush cycle
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    @(negedge clk); check_val("rr1_flush", int'(bi.flush), 1);
    tick();
    idle();
    @(negedge clk); check_val("rr2_flush", int'(bi.flush), 1);
    tick();
    @(negedge clk); check_val("rr3_flush", int'(bi.flush), 1);
    tick();
    @(negedge clk); check_val("rr4_flush", int'(bi.flush), 0);
    tick();
    drain();

    // Async reset while stalled with two entries in flight
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    drv(1'b1, 5'd4, 1'b1, 5'd3, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    #1;
    check_val("ar_pre_stall", int'(bi.stall), 1);
    check_val("ar_pre_inflight", int'(bi.inflight), 2);
    check_val("ar_pre_sel2", int'(bi.fwd_sel_rs2), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("ar_stall", int'(bi.stall), 0);
    check_val("ar_inflight", int'(bi.inflight), 0);
    check_val("ar_sel1", int'(bi.fwd_sel_rs1), 0);
    check_val("ar_sel2", int'(bi.fwd_sel_rs2), 0);
    check_val("ar_flush", int'(bi.flush), 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check_val("ar_post_sel1", int'(bi.fwd_sel_rs1), 0);
    check_val("ar_post_stall", int'(bi.stall), 0);
    tick();
    drain();

    // Load-use with LOAD_STAGE = 3: two stall cycles, then stage-3 forward
    bi3.issue_valid = 1'b1; bi3.issue_rd = 5'd5; bi3.issue_wr = 1'b1; bi3.issue_is_load = 1'b1;
    tick();
    bi3.issue_rd = 5'd6; bi3.issue_is_load = 1'b0; bi3.issue_rs1 = 5'd5; bi3.issue_use_rs1 = 1'b1;
    @(negedge clk); check_val("ls3_stall1", int'(bi3.stall), 1);
    tick();
    @(negedge clk); check_val("ls3_stall2", int'(bi3.stall), 1);
    tick();
    @(negedge clk);
    check_val("ls3_stall_clr", int'(bi3.stall), 0);
    check_val("ls3_sel1", int'(bi3.fwd_sel_rs1), 3);
    tick();
    bi3.issue_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
